// File: rtl/sw_input_reader.sv
// Switch input reader: 2-flop sync, per-bit debounce, rise/fall strobes,
// and a one-deep valid/ready change-event slot with sticky overrun flag.
//
// Ports:
//   mclk, rst_n      clock, synchronous active-low reset
//   sw               raw asynchronous switch levels
//   sw_stable        debounced levels
//   rise, fall       one-cycle strobes on debounced edges
//   ev_valid/ev_ready event handshake; ev_idx/ev_level describe the event
//   ev_lost          sticky, an event was overwritten before being reported
module sw_input_reader #(
  parameter int N_IN    = 16,
  parameter int DEB_CNT = 1_000_000,
  parameter int CNT_W   = $clog2(DEB_CNT)
) (
  input  logic            mclk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] sw,
  output logic [N_IN-1:0] sw_stable,
  output logic [N_IN-1:0] rise,
  output logic [N_IN-1:0] fall,
  output logic            ev_valid,
  output logic [3:0]      ev_idx,
  output logic            ev_level,
  input  logic            ev_ready,
  output logic            ev_lost
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CNT - 1);

  logic [N_IN-1:0]  s1_q, s1_d;
  logic [N_IN-1:0]  s2_q, s2_d;
  logic [N_IN-1:0]  stable_q, stable_d;
  logic [N_IN-1:0]  rise_q, rise_d;
  logic [N_IN-1:0]  fall_q, fall_d;
  logic [N_IN-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q [N_IN];
  logic [CNT_W-1:0] cnt_d [N_IN];
  state_t           state_q, state_d;
  logic [3:0]       ev_idx_q, ev_idx_d;
  logic             ev_level_q, ev_level_d;
  logic             ev_lost_q, ev_lost_d;

  logic [N_IN-1:0]  tog;
  logic [N_IN-1:0]  pick_oh;
  logic [N_IN-1:0]  clr;
  logic [3:0]       pick_idx;
  logic             hs;
  logic             load;

  always_comb begin
    s1_d = sw;
    s2_d = s1_q;
    tog  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i] = '0;
        tog[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    stable_d = stable_q ^ tog;
    rise_d   = tog & s2_q;
    fall_d   = tog & ~s2_q;

    // lowest set pending bit, as one-hot and as index
    pick_oh  = pend_q & (~pend_q + 1'b1);
    pick_idx = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (pend_q[i]) pick_idx = 4'(i);
    end

    hs   = (state_q == FULL) && ev_ready;
    load = (|pend_q) && ((state_q == EMPTY) || hs);

    state_d = state_q;
    unique case (state_q)
      EMPTY: if (|pend_q) state_d = FULL;
      FULL:  if (hs && !(|pend_q)) state_d = EMPTY;
    endcase

    clr = load ? pick_oh : '0;
    // a toggle on the clearing edge re-arms the bit (set wins)
    pend_d    = (pend_q & ~clr) | tog;
    ev_lost_d = ev_lost_q | (|(tog & pend_q & ~clr));

    ev_idx_d   = load ? pick_idx : ev_idx_q;
    ev_level_d = load ? |(stable_q & pick_oh) : ev_level_q;
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      stable_q   <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      pend_q     <= '0;
      state_q    <= EMPTY;
      ev_idx_q   <= '0;
      ev_level_q <= 1'b0;
      ev_lost_q  <= 1'b0;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      stable_q   <= stable_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      ev_idx_q   <= ev_idx_d;
      ev_level_q <= ev_level_d;
      ev_lost_q  <= ev_lost_d;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sw_stable = stable_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign ev_valid  = (state_q == FULL);
  assign ev_idx    = ev_idx_q;
  assign ev_level  = ev_level_q;
  assign ev_lost   = ev_lost_q;

endmodule
